// File: rtl/water_supply_arbiter_if.sv
// Request/grant bundle between the per-machine water controllers and the
// shared inlet-valve arbiter.
interface water_supply_arbiter_if #(
    parameter int N_MACHINES = 4,
    parameter int ID_W       = $clog2(N_MACHINES)
);
    logic [N_MACHINES-1:0] i_req;
    logic [N_MACHINES-1:0] i_pause;
    logic [N_MACHINES-1:0] o_grant;
    logic [ID_W-1:0]       o_grant_id;
    logic                  o_valve_open;
    logic                  o_busy;
    logic                  o_timeout;

    modport slave (
        input  i_req, i_pause,
        output o_grant, o_grant_id, o_valve_open, o_busy, o_timeout
    );

    modport master (
        output i_req, i_pause,
        input  o_grant, o_grant_id, o_valve_open, o_busy, o_timeout
    );
endinterface

// File: rtl/water_supply_arbiter.sv
// Round-robin owner of the single mains inlet valve: one machine at a time,
// bounded open time, dead-time between owners, grant frozen while lid is open.
module water_supply_arbiter #(
    parameter int N_MACHINES        = 4,
    parameter int MAX_GRANT_CYCLES  = 50_000_000,
    parameter int SWITCH_GAP_CYCLES = 5,
    parameter int CNT_W             = 31,
    parameter int ID_W              = $clog2(N_MACHINES)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    water_supply_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_GAP} state_t;

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(MAX_GRANT_CYCLES - 1);
    localparam logic [CNT_W-1:0]      GAP_LAST =
        CNT_W'((SWITCH_GAP_CYCLES > 0) ? SWITCH_GAP_CYCLES - 1 : 0);
    localparam logic [N_MACHINES-1:0] ONE_HOT0 = N_MACHINES'(1);
    localparam logic [ID_W-1:0]       ID_RST   = ID_W'(N_MACHINES - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [N_MACHINES-1:0] r_grant;
    logic [ID_W-1:0]       r_grant_id;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      r_gap_cnt;
    logic                  r_timeout;

    logic [N_MACHINES-1:0] w_elig;
    logic                  w_sel_vld;
    logic [ID_W-1:0]       w_sel_idx;
    logic                  w_req_cur;
    logic                  w_pause_cur;
    logic                  w_valve;
    logic                  w_release;
    logic                  w_rel_timeout;

    assign w_elig      = bus.i_req & ~bus.i_pause;
    assign w_req_cur   = bus.i_req[r_grant_id];
    assign w_pause_cur = bus.i_pause[r_grant_id];
    assign w_valve     = (r_state == ST_GRANT) & w_req_cur & ~w_pause_cur;

    // Scan from farthest to nearest so the last hit is the first eligible
    // index after the pointer (the last granted machine).
    always_comb begin
        logic [ID_W-1:0] v_idx;
        w_sel_vld = 1'b0;
        w_sel_idx = '0;
        v_idx     = '0;
        for (int i = N_MACHINES; i >= 1; i--) begin
            v_idx = ID_W'((int'(r_grant_id) + i) % N_MACHINES);
            if (w_elig[v_idx]) begin
                w_sel_vld = 1'b1;
                w_sel_idx = v_idx;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // A dropped request wins over the open-time limit, so a release in the
    // same cycle as the limit is never reported as a timeout.
    always_comb begin
        w_state_nxt   = r_state;
        w_release     = 1'b0;
        w_rel_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_vld) w_state_nxt = ST_GRANT;
            end
            ST_GRANT: begin
                if (!w_req_cur) begin
                    w_release = 1'b1;
                end else if (w_valve && (r_cnt == CNT_LAST)) begin
                    w_release     = 1'b1;
                    w_rel_timeout = 1'b1;
                end
                if (w_release)
                    w_state_nxt = (SWITCH_GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_grant    <= '0;
            r_grant_id <= ID_RST;
            r_cnt      <= '0;
            r_gap_cnt  <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_rel_timeout;
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_vld) begin
                        r_grant    <= ONE_HOT0 << w_sel_idx;
                        r_grant_id <= w_sel_idx;
                        r_cnt      <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_grant   <= '0;
                        r_gap_cnt <= '0;
                    end else if (w_valve) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    r_gap_cnt <= r_gap_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_grant      = r_grant;
    assign bus.o_grant_id   = r_grant_id;
    assign bus.o_valve_open = w_valve;
    assign bus.o_busy       = (r_state != ST_IDLE);
    assign bus.o_timeout    = r_timeout;

endmodule

// File: tb/tb_water_supply_arbiter.sv
// Bench for water_supply_arbiter: directed scenarios plus random traffic, all
// compared against an owner/remaining-time model of the arbiter.
module tb_water_supply_arbiter;
    localparam int N   = 4;
    localparam int MAX = 8;
    localparam int GAP = 2;

    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    water_supply_arbiter_if #(.N_MACHINES(N)) bus();

    water_supply_arbiter #(
        .N_MACHINES(N), .MAX_GRANT_CYCLES(MAX),
        .SWITCH_GAP_CYCLES(GAP), .CNT_W(31)
    ) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: who owns the valve, how many open cycles it has left,
    // how many dead-time cycles remain, and the last machine served.
    int m_owner, m_ptr, m_open_left, m_gap_left;
    bit m_to;

    wire [8:0] dut_vec = {bus.o_grant, bus.o_grant_id, bus.o_valve_open,
                          bus.o_busy, bus.o_timeout};

    task automatic model_reset();
        m_owner = -1; m_ptr = N - 1; m_open_left = 0; m_gap_left = 0; m_to = 0;
    endtask

    task automatic model_step(input logic [3:0] req, input logic [3:0] pause);
        bit to_n = 0;
        if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_owner = -1; m_gap_left = GAP;
            end else if (!pause[m_owner]) begin
                m_open_left--;
                if (m_open_left == 0) begin
                    m_owner = -1; m_gap_left = GAP; to_n = 1;
                end
            end
        end else if (m_gap_left > 0) begin
            m_gap_left--;
        end else begin
            for (int i = 1; i <= N; i++) begin
                int k = (m_ptr + i) % N;
                if (req[k] && !pause[k]) begin
                    m_owner = k; m_ptr = k; m_open_left = MAX;
                    break;
                end
            end
        end
        m_to = to_n;
    endtask

    function automatic logic [8:0] exp_vec();
        logic [3:0] g;
        logic v, b;
        g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
        v = (m_owner >= 0) && bus.i_req[m_owner] && !bus.i_pause[m_owner];
        b = (m_owner >= 0) || (m_gap_left > 0);
        return {g, 2'(m_ptr), v, b, m_to};
    endfunction

    task automatic tick(input logic [3:0] req, input logic [3:0] pause);
        bus.i_req = req; bus.i_pause = pause;
        @(posedge clk);
        model_step(req, pause);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.i_req = '0; bus.i_pause = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.i_req = '0; bus.i_pause = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        n_chk++;
        if (dut_vec !== 9'b0000_11_0_0_0)
            $display("FAIL reset_values: got %b want %b", dut_vec, 9'b0000_11_0_0_0);
        else n_pass++;
        rst = 1'b0;
        tick(4'b0000, 4'b0000);
        n_chk++;
        if (dut_vec !== exp_vec()) $display("FAIL reset_idle: got %b want %b", dut_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_single();
        int opens = 0, nz = 0, cyc = 0;
        do_reset();
        tick(4'b0010, 4'b0000);
        n_chk++;
        if (bus.o_grant !== 4'b0010) $display("FAIL single_grant: got %b want 0010", bus.o_grant);
        else n_pass++;
        while (bus.o_grant != 0 && cyc < 100) begin
            if (bus.o_valve_open) opens++;
            n_chk++;
            if (dut_vec !== exp_vec()) $display("FAIL single_model: got %b want %b", dut_vec, exp_vec());
            else n_pass++;
            tick(4'b0010, 4'b0000); cyc++;
        end
        n_chk++;
        if (opens != MAX) $display("FAIL single_open_cycles: got %0d want %0d", opens, MAX);
        else n_pass++;
        n_chk++;
        if (bus.o_timeout !== 1'b1) $display("FAIL single_timeout: got %b want 1", bus.o_timeout);
        else n_pass++;
        while (bus.o_grant == 0 && cyc < 100) begin
            nz++;
            tick(4'b0010, 4'b0000); cyc++;
            n_chk++;
            if (bus.o_timeout !== 1'b0) $display("FAIL single_timeout_pulse: got %b want 0", bus.o_timeout);
            else n_pass++;
        end
        n_chk++;
        if (nz != GAP + 1) $display("FAIL single_gap_len: got %0d want %0d", nz, GAP + 1);
        else n_pass++;
        n_chk++;
        if (bus.o_grant !== 4'b0010) $display("FAIL single_regrant: got %b want 0010", bus.o_grant);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [3:0] want [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0] prev = '0;
        int got = 0, cyc = 0;
        do_reset();
        while (got < 5 && cyc < 300) begin
            tick(4'b1111, 4'b0000); cyc++;
            n_chk++;
            if (dut_vec !== exp_vec()) $display("FAIL rr_model: got %b want %b", dut_vec, exp_vec());
            else n_pass++;
            if (bus.o_grant != 0 && prev == 0) begin
                n_chk++;
                if (bus.o_grant !== want[got])
                    $display("FAIL rr_order_%0d: got %b want %b", got, bus.o_grant, want[got]);
                else n_pass++;
                got++;
            end
            prev = bus.o_grant;
        end
        n_chk++;
        if (got != 5) $display("FAIL rr_count: got %0d want 5", got);
        else n_pass++;
    endtask

    task automatic test_early_release();
        int nz = 0, cyc = 0;
        do_reset();
        tick(4'b1100, 4'b0000);
        n_chk++;
        if (bus.o_grant !== 4'b0100) $display("FAIL early_grant: got %b want 0100", bus.o_grant);
        else n_pass++;
        tick(4'b1100, 4'b0000);
        tick(4'b1100, 4'b0000);
        tick(4'b1000, 4'b0000);
        n_chk++;
        if ({bus.o_grant, bus.o_timeout} !== 5'b0000_0)
            $display("FAIL early_release: got %b want 00000", {bus.o_grant, bus.o_timeout});
        else n_pass++;
        while (bus.o_grant == 0 && cyc < 50) begin
            nz++;
            n_chk++;
            if (dut_vec !== exp_vec()) $display("FAIL early_model: got %b want %b", dut_vec, exp_vec());
            else n_pass++;
            tick(4'b1000, 4'b0000); cyc++;
        end
        n_chk++;
        if (nz != GAP + 1 || bus.o_grant !== 4'b1000)
            $display("FAIL early_next: got gap %0d grant %b want gap %0d grant 1000", nz, bus.o_grant, GAP + 1);
        else n_pass++;
    endtask

    task automatic test_pause();
        int opens = 0, gcyc = 0, cyc = 0;
        do_reset();
        tick(4'b0010, 4'b0000);
        gcyc++;
        repeat (3) begin tick(4'b0010, 4'b0000); gcyc++; end
        repeat (5) begin
            tick(4'b0010, 4'b0010); gcyc++;
            n_chk++;
            if ({bus.o_grant, bus.o_valve_open} !== 5'b0010_0)
                $display("FAIL pause_hold: got %b want 00100", {bus.o_grant, bus.o_valve_open});
            else n_pass++;
        end
        tick(4'b0010, 4'b0000);
        while (bus.o_grant != 0 && cyc < 50) begin
            gcyc++;
            if (bus.o_valve_open) opens++;
            n_chk++;
            if (dut_vec !== exp_vec()) $display("FAIL pause_model: got %b want %b", dut_vec, exp_vec());
            else n_pass++;
            tick(4'b0010, 4'b0000); cyc++;
        end
        n_chk++;
        if (opens != 4 || gcyc != 13)
            $display("FAIL pause_resume: got opens %0d total %0d want opens 4 total 13", opens, gcyc);
        else n_pass++;
    endtask

    task automatic test_ineligible();
        int cyc = 0;
        do_reset();
        tick(4'b0011, 4'b0001);
        n_chk++;
        if (bus.o_grant !== 4'b0010) $display("FAIL inelig_first: got %b want 0010", bus.o_grant);
        else n_pass++;
        repeat (3) tick(4'b0011, 4'b0001);
        while (bus.o_grant != 0 && cyc < 50) begin tick(4'b0011, 4'b0000); cyc++; end
        while (bus.o_grant == 0 && cyc < 50) begin tick(4'b0011, 4'b0000); cyc++; end
        n_chk++;
        if (bus.o_grant !== 4'b0001) $display("FAIL inelig_second: got %b want 0001", bus.o_grant);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(4'b0100, 4'b0000);
        tick(4'b0100, 4'b0000);
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        n_chk++;
        if (dut_vec !== 9'b0000_11_0_0_0)
            $display("FAIL reset_mid: got %b want %b", dut_vec, 9'b0000_11_0_0_0);
        else n_pass++;
        n_chk++;
        if (dut_vec !== exp_vec()) $display("FAIL reset_mid_model: got %b want %b", dut_vec, exp_vec());
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] req = '0, pause = '0;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0)
                pause = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            tick(req, pause);
            n_chk++;
            if (dut_vec !== exp_vec())
                $display("FAIL random_c%0d: got %b want %b (req %b pause %b)", c, dut_vec, exp_vec(), req, pause);
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.i_req = '0;
        bus.i_pause = '0;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_early_release();
        test_pause();
        test_ineligible();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/water_supply_arbiter.md
# water_supply_arbiter

Shares the single mains water-inlet valve of a multi-machine laundromat between up to N washing-machine controllers, each of which raises a request whenever it is in a water-filling phase. It grants the valve to one machine at a time in round-robin order and caps each grant with a maximum open time. It inserts a valve-settling dead-time between grants and freezes a grant while that machine's lid is open. It sits between the per-machine controllers' water-inlet outputs and the physical valve driver.

## Interface
- N_MACHINES, 4, number of requesters (2..8)
- MAX_GRANT_CYCLES, 50_000_000, maximum valve-open cycles per grant (1 s at 50 MHz); must be ≥1
- SWITCH_GAP_CYCLES, 5, dead-time cycles with no grant between grants; 0 allowed
- CNT_W, 31, width of the grant and gap counters; must hold MAX_GRANT_CYCLES
- i_clk  in  1  system clock, 50 MHz; all logic is on the rising edge
- i_rst  in  1  synchronous, active-high reset
- i_req  in  N_MACHINES  per-machine water request (the machine's water-inlet signal), level
- i_pause  in  N_MACHINES  per-machine lid-open flag, level
- o_grant  out  N_MACHINES  one-hot grant, registered; all-zero when no grant is held
- o_grant_id  out  clog2(N_MACHINES)  index of the current or last granted machine, registered
- o_valve_open  out  1  drives the valve; = (state==GRANT) & i_req[id] & ~i_pause[id]
- o_busy  out  1  high in the GRANT and GAP states
- o_timeout  out  1  one-cycle pulse when a grant is ended by MAX_GRANT_CYCLES

## Operation
- States: IDLE, GRANT, GAP.
- Eligibility: machine k is eligible when i_req[k] & ~i_pause[k].
- **IDLE**
  - If any machine is eligible, select the first eligible index after the round-robin pointer, wrapping modulo N.
  - Next edge: load o_grant/o_grant_id, clear the grant counter, enter GRANT, and set the pointer to the granted index.
  - If no machine is eligible, stay in IDLE.
- **GRANT**
  - The grant counter increments on every cycle in which o_valve_open=1.
  - While i_pause[id]=1: the valve is closed, the counter is frozen and the grant is held.
  - Release when i_req[id]=0 (pause state irrelevant), or when the counter reaches MAX_GRANT_CYCLES-1 with the valve open. That is the final open cycle, so the valve is open exactly MAX_GRANT_CYCLES cycles.
  - On the release edge: o_grant goes to 0, o_grant_id holds, and the FSM enters GAP, or IDLE directly if SWITCH_GAP_CYCLES=0.
- **GAP**
  - No grant and the valve is closed.
  - The gap counter starts at 0 and GAP lasts exactly SWITCH_GAP_CYCLES cycles, then the FSM enters IDLE.
  - Requests are ignored in GAP.
- o_timeout is registered: it is high for the first cycle after the release edge, and only for timeout releases.
- Because the pointer advances, a timed-out machine that re-requests is granted again only after every other eligible requester has been served.
- A request or lid change by a non-granted machine never disturbs the current grant.

## Timing
- Reset values: o_grant=0, o_grant_id=N_MACHINES-1 (machine 0 has first priority), o_valve_open=0, o_busy=0, o_timeout=0; state IDLE; both counters 0.
- Grant latency: eligible request sampled in IDLE at edge t → o_grant valid after edge t. o_valve_open follows combinationally in the same cycle.
- Release-to-next-grant: the grant drops at edge r. The next grant is registered SWITCH_GAP_CYCLES+1 edges later (GAP cycles plus one IDLE cycle).
- Simultaneous request drop and counter limit: the release counts as normal and o_timeout stays 0.
- Request drops while the machine is paused: release normally.
- i_rst asserted mid-grant: all outputs are at reset values after that edge, and the valve closes immediately.
- No eligible requester after GAP: remain in IDLE with the pointer unchanged.

## Test plan
Parameters for all scenarios: N=4, MAX=8, GAP=2.

- **Reset and single grant:** reset, then i_req=0010 → o_grant=0010 one cycle later. o_valve_open=1 for 8 cycles, then o_timeout pulses once and o_grant=0000 for 2 GAP cycles plus 1 IDLE cycle. The grant returns to 0010 if the request is held.
- **Round-robin:** i_req=1111 held → grant order 0001, 0010, 0100, 1000, 0001. Each grant lasts 8 open cycles and consecutive grants are separated by 3 no-grant cycles.
- **Early release:** machine 2 is granted and drops i_req after 3 open cycles → o_grant=0000 on the next edge and o_timeout=0. Machine 3, already requesting, is granted 3 edges later.
- **Lid pause:** machine 1 is granted; i_pause[1]=1 for 5 cycles after 4 open cycles → o_valve_open=0 and o_grant held during the pause. The grant resumes and ends after 4 more open cycles, 13 grant cycles in total.
- **Ineligible in IDLE:** i_req=0011, i_pause=0001 → machine 1 is granted first. Machine 0 is granted only after i_pause[0] clears.
- **Reset mid-grant:** i_rst for one cycle during the GRANT state → the next cycle shows o_grant=0, o_valve_open=0, o_grant_id=3, o_busy=0.
